// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core.
// Optional feature: CTRL_UTYPE_EN adds the LUI/AUIPC states.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2,
`ifdef CTRL_UTYPE_EN
    S_LUI,
    S_AUIPC,
`endif
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from op class and instruction fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       rtype,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          // sltu shares the slt encoding
          3'b011:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core.
// Optional feature: CTRL_UTYPE_EN enables LUI/AUIPC; otherwise those opcodes trap.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       retire,
  output logic       illegal
);

  state_t state, state_nxt;
  aluop_t alu_op;
  logic   rtype;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_START;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    rtype      = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ack;
        pc_write   = mem_ack;
        if (mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR1;
`ifdef CTRL_UTYPE_EN
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
`endif
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        // op[5] separates stores (0100011) from loads (0000011)
        imm_src   = op[5] ? IMM_S : IMM_I;
        state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ack) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ack;
        if (mem_ack) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        rtype     = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        pc_write  = funct3[0] ? !zero : zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_JALR1: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_nxt = S_JALR2;
      end
`ifdef CTRL_UTYPE_EN
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
`endif
      S_TRAP: illegal = 1'b1;
      default: state_nxt = S_START;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .rtype       (rtype),
    .alu_control (alu_control)
  );

endmodule
